lsu_controller: RTL and testbench

Multi-cycle load/store sequencer between the RV32I core and a handshaked data-memory bus. It takes load/store requests from decode, stalls the core while a bus transaction is outstanding, and returns sign- or zero-extended load data. It generates byte enables and lane-replicated store data, and aborts on bus timeout. It sits between the ALU result/register-file read ports and the data memory, alongside the main decode controller.

---
 rtl/lsu_controller.sv | 188 ++++++++++++++++++
 tb/tb_lsu_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// Load/store sequencer between the RV32I core and a handshaked data-memory bus.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses raise err instead of being force-aligned.
module lsu_controller #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT);

   state_t      state;
   logic [7:0]  cnt;
   logic        lat_we;
   logic [2:0]  lat_f3;
   logic [1:0]  lat_lo;

   logic        illegal;
   logic        misal;
   logic [3:0]  be_next;
   logic [31:0] wd_next;
   logic [31:0] load_data;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        timeout_hit;

   assign stall       = ((state == S_IDLE) && mem_en) || (state == S_WAIT);
   assign timeout_hit = (({1'b0, cnt} + 9'd1) == TO_LIMIT);

   // Decode legality, byte enables and lane-replicated store data for the issuing access.
   always_comb begin
      illegal = 1'b0;
      misal   = 1'b0;
      be_next = 4'b0000;
      wd_next = 32'd0;
      if (mem_we) begin
         illegal = func3[2] || (func3[1:0] == 2'b11);
      end else begin
         illegal = (func3 == 3'b011) || (func3[2:1] == 2'b11);
      end
`ifdef LSU_MISALIGN_TRAP_EN
      case (func3[1:0])
         2'b01:   misal = addr[0];
         2'b10:   misal = (addr[1:0] != 2'b00);
         default: misal = 1'b0;
      endcase
`else
      misal = 1'b0;
`endif
      case (func3[1:0])
         2'b00: begin
            be_next = 4'b0001 << addr[1:0];
            wd_next = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_next = 4'b0011 << {addr[1], 1'b0};
            wd_next = {2{wdata[15:0]}};
         end
         2'b10: begin
            be_next = 4'b1111;
            wd_next = wdata;
         end
         default: begin
            be_next = 4'b0000;
            wd_next = 32'd0;
         end
      endcase
   end

   // Select the addressed lane of the returned word and extend it.
   always_comb begin
      byte_lane = 8'd0;
      half_lane = 16'd0;
      load_data = 32'd0;
      case (lat_lo)
         2'b00:   byte_lane = bus_rdata[7:0];
         2'b01:   byte_lane = bus_rdata[15:8];
         2'b10:   byte_lane = bus_rdata[23:16];
         2'b11:   byte_lane = bus_rdata[31:24];
         default: byte_lane = 8'd0;
      endcase
      if (lat_lo[1]) begin
         half_lane = bus_rdata[31:16];
      end else begin
         half_lane = bus_rdata[15:0];
      end
      case (lat_f3)
         3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
         3'b010:  load_data = bus_rdata;
         3'b100:  load_data = {24'd0, byte_lane};
         3'b101:  load_data = {16'd0, half_lane};
         default: load_data = 32'd0;
      endcase
   end

   // Sequencer FSM with registered bus and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         lat_we    <= 1'b0;
         lat_f3    <= 3'b000;
         lat_lo    <= 2'b00;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'd0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_en) begin
                  if (illegal || misal) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                     rdata <= 32'd0;
                  end else begin
                     state     <= S_WAIT;
                     cnt       <= 8'd0;
                     lat_we    <= mem_we;
                     lat_f3    <= func3;
                     lat_lo    <= addr[1:0];
                     bus_req   <= 1'b1;
                     bus_we    <= mem_we;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_be    <= be_next;
                     bus_wdata <= wd_next;
                  end
               end
            end
            S_WAIT: begin
               // An ack in the final WAIT cycle takes priority over the timeout.
               if (bus_ack) begin
                  state   <= S_DONE;
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  rdata   <= lat_we ? 32'd0 : load_data;
               end else if (timeout_hit) begin
                  state   <= S_DONE;
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  err     <= 1'b1;
                  rdata   <= 32'd0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed plus randomized bench for lsu_controller against an arithmetic reference model.
module tb_lsu_controller;

   localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en;
   logic        mem_we;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] exp_hold;
   bit          hold_known;

   lsu_controller #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .func3(func3),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input bit we, input logic [2:0] f3);
      if (we) return (f3 <= 3'd2);
      return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
   endfunction

   function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
      int size = int'(f3) % 4;
      if (size == 1) return (a % 2) != 0;
      if (size == 2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int size = int'(f3) % 4;
      if (size == 0) return 4'(1 << (a % 4));
      if (size == 1) return 4'(3 << (((a / 2) % 2) * 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
      int size = int'(f3) % 4;
      if (size == 0) return (wd % 256) * 32'h0101_0101;
      if (size == 1) return (wd % 65536) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      longint unsigned v;
      longint unsigned top;
      int size = int'(f3) % 4;
      if (size == 2) return w;
      if (size == 0) begin
         v   = (longint'(w) >> (8 * (a % 4))) % 256;
         top = 128;
      end else begin
         v   = (longint'(w) >> (16 * ((a / 2) % 2))) % 65536;
         top = 32768;
      end
      if (f3 < 3'd4 && v >= top) return 32'(v + 64'h1_0000_0000 - 2 * top);
      return 32'(v);
   endfunction

   task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int delay, input logic [31:0] brd,
                         input string nm);
      bit bad;
      bit acked;
      logic [31:0] exp_rd;
      bad = !is_legal(we, f3) || (TRAP && is_misal(f3, a));
      @(negedge clk);
      mem_en = 1'b1; mem_we = we; func3 = f3; addr = a; wdata = wd; bus_ack = 1'b0;
      #1;
      check({nm, " stall_issue"}, 32'(stall), 32'd1);
      check({nm, " done_issue"}, 32'(done), 32'd0);
      @(negedge clk);
      if (bad) begin
         check({nm, " err_done"}, 32'(done), 32'd1);
         check({nm, " err_flag"}, 32'(err), 32'd1);
         check({nm, " err_rdata"}, rdata, 32'd0);
         check({nm, " err_nobus"}, 32'(bus_req), 32'd0);
         check({nm, " err_stall"}, 32'(stall), 32'd0);
         exp_hold   = 32'd0;
         hold_known = 1'b1;
      end else begin
         acked = 1'b0;
         for (int i = 0; i < TO; i++) begin
            check({nm, " wait_req"}, 32'(bus_req), 32'd1);
            check({nm, " wait_stall"}, 32'(stall), 32'd1);
            check({nm, " wait_done"}, 32'(done), 32'd0);
            check({nm, " bus_addr"}, bus_addr, a & 32'hFFFF_FFFC);
            check({nm, " bus_be"}, 32'(bus_be), 32'(model_be(f3, a)));
            check({nm, " bus_we"}, 32'(bus_we), 32'(we));
            if (we) check({nm, " bus_wdata"}, bus_wdata, model_wd(f3, wd));
            if (i == delay) begin
               bus_ack = 1'b1; bus_rdata = brd; acked = 1'b1;
            end else begin
               bus_ack = 1'b0; bus_rdata = $urandom;
            end
            @(negedge clk);
            bus_ack = 1'b0;
            if (acked) break;
         end
         check({nm, " done"}, 32'(done), 32'd1);
         check({nm, " done_err"}, 32'(err), 32'(!acked));
         check({nm, " done_stall"}, 32'(stall), 32'd0);
         check({nm, " done_req"}, 32'(bus_req), 32'd0);
         if (!we || !acked) begin
            exp_rd = acked ? model_load(f3, a, brd) : 32'd0;
            check({nm, " rdata"}, rdata, exp_rd);
            exp_hold   = exp_rd;
            hold_known = 1'b1;
         end else begin
            hold_known = 1'b0;
         end
      end
      @(negedge clk);
      mem_en  = 1'b0;
      bus_ack = 1'($urandom % 2);
      #1;
      check({nm, " idle_done"}, 32'(done), 32'd0);
      check({nm, " idle_err"}, 32'(err), 32'd0);
      check({nm, " idle_stall"}, 32'(stall), 32'd0);
      check({nm, " idle_req"}, 32'(bus_req), 32'd0);
      if (hold_known) check({nm, " rdata_hold"}, rdata, exp_hold);
   endtask

   initial begin
      rst = 1'b1; mem_en = 1'b0; mem_we = 1'b0; func3 = 3'd0; addr = 32'd0;
      wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0; exp_hold = 32'd0; hold_known = 1'b1;
      repeat (2) @(negedge clk);
      check("rst bus_req", 32'(bus_req), 32'd0);
      check("rst bus_we", 32'(bus_we), 32'd0);
      check("rst bus_addr", bus_addr, 32'd0);
      check("rst bus_be", 32'(bus_be), 32'd0);
      check("rst bus_wdata", bus_wdata, 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst err", 32'(err), 32'd0);
      check("rst rdata", rdata, 32'd0);
      check("rst stall0", 32'(stall), 32'd0);
      mem_en = 1'b1; #1;
      check("rst stall1", 32'(stall), 32'd1);
      mem_en = 1'b0;
      @(negedge clk); rst = 1'b0;

      access(1'b0, 3'b010, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF, "lw");
      access(1'b0, 3'b000, 32'h0000_0203, 32'd0, 0, 32'h80FF_FF00, "lb");
      access(1'b0, 3'b100, 32'h0000_0203, 32'd0, 0, 32'h80FF_FF00, "lbu");
      access(1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 3, 32'd0, "sh");
      access(1'b0, 3'b010, 32'h0000_0400, 32'd0, TO + 5, 32'd0, "lw_timeout");
      access(1'b1, 3'b010, 32'h0000_0101, 32'h5555_AAAA, 1, 32'd0, "sw_misal");
      access(1'b0, 3'b011, 32'h0000_0500, 32'd0, 0, 32'd0, "ld_f3_011");
      access(1'b1, 3'b100, 32'h0000_0500, 32'd7, 0, 32'd0, "st_f3_100");

      // Reset in the middle of a WAIT, then a late ack that must be ignored.
      @(negedge clk);
      mem_en = 1'b1; mem_we = 1'b0; func3 = 3'b010; addr = 32'h0000_0040;
      @(negedge clk);
      check("midrst req_before", 32'(bus_req), 32'd1);
      rst = 1'b1; #1;
      check("midrst req_drop", 32'(bus_req), 32'd0);
      check("midrst stall", 32'(stall), 32'd1);
      mem_en = 1'b0; #1;
      check("midrst stall_off", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      @(negedge clk);
      bus_ack = 1'b0;
      check("late_ack done", 32'(done), 32'd0);
      check("late_ack req", 32'(bus_req), 32'd0);
      check("late_ack rdata", rdata, 32'd0);
      access(1'b0, 3'b001, 32'h0000_0046, 32'd0, 1, 32'h8001_7FFF, "lh_after_rst");

      for (int n = 0; n < 300; n++) begin
         access(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom,
                int'($urandom_range(0, TO + 1)), $urandom, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
